// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO.
// It has a standard (registered) read mode and a first-word-fall-through read mode.
// DEPTH can be any value of 2 or more, including non-powers of two.
// The almost-full and almost-empty thresholds are set at elaboration time.
// Overflow and underflow are sticky flags that stay set until clr_err or rst.
// A push to a full FIFO is accepted when a pop is accepted in the same cycle.
module sync_fifo_flex #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_en,
    input  logic                       pop_en,
    input  logic [DATA_W-1:0]          din,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_acc, pop_acc;

    // A pop needs data that is already stored, so a push in the same cycle cannot satisfy it.
    // A push to a full FIFO is accepted only when the same cycle frees a slot with a pop.
    assign empty        = (level_q == '0);
    assign full         = (level_q == FULL_LVL);
    assign almost_full  = (int'(level_q) >= AF_THRESH);
    assign almost_empty = (int'(level_q) <= AE_THRESH);
    assign pop_acc      = pop_en && !empty;
    assign push_acc     = push_en && (!full || pop_acc);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Next state for the pointers, the fill level and the sticky error flags.
    // Pointers wrap with an explicit compare, which keeps non-power-of-two depths correct.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_acc && !pop_acc) begin
            level_d = level_q + 1'b1;
        end else if (pop_acc && !push_acc) begin
            level_d = level_q - 1'b1;
        end
        if (push_en && !push_acc) begin
            overflow_d = 1'b1;
        end
        if (pop_en && !pop_acc) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register; reset discards contents by zeroing pointers and level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; it is not reset, and nothing is written while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // The head word is shown directly.
        // dout is forced to zero while the FIFO is empty so that stale contents never appear.
        assign dout       = empty ? '0 : mem_q[rd_ptr_q];
        assign dout_valid = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              dout_valid_q, dout_valid_d;

        // The popped word is registered, so dout_valid is a one-cycle pulse for each accepted pop.
        always_comb begin
            dout_d       = dout_q;
            dout_valid_d = pop_acc;
            if (pop_acc) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end

        // Read output register.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end

endmodule
